digit_entry_ctrl: RTL and testbench

- Sequences two-digit numeric entry from the keyboard decoder, e.g. a thermostat setpoint or alarm code digit pair.
- Collects a tens keystroke, then a units keystroke, with an inter-key timeout.
- Validates both nibbles as decimal digits and range-checks the combined value.
- Publishes an accepted BCD value, or a one-cycle error pulse, to the home-simulation control FSM.

---
 rtl/digit_entry_ctrl.sv | 148 ++++++++++++++
 tb/tb_digit_entry_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/digit_entry_ctrl.sv
// Two-digit keypad entry sequencer: tens key, units key with inter-key timeout, then
// validate and publish a BCD value or an error pulse. Optional macro DIGIT_ENTRY_BIN_OUT_EN adds value_bin_o.
module digit_entry_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned TIMER_W        = 26,
    parameter int unsigned MAX_VALUE      = 99,
    parameter logic [3:0]  CLEAR_CODE     = 4'hC
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       key_valid_i,
    input  logic [3:0] key_code_i,
    output logic [7:0] value_bcd_o,
    output logic       value_valid_o,
    output logic       error_o,
    output logic       busy_o,
    output logic [2:0] state_dbg_o
`ifdef DIGIT_ENTRY_BIN_OUT_EN
    ,
    output logic [6:0] value_bin_o
`endif
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWait2 = 3'd1,
        StCheck = 3'd2,
        StDone  = 3'd3,
        StErr   = 3'd4
    } state_e;

    localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]         MaxVal    = 7'(MAX_VALUE);

    state_e               state_q, state_d;
    logic [3:0]           tens_q, tens_d;
    logic [3:0]           units_q, units_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [7:0]           value_bcd_q, value_bcd_d;
    logic                 value_valid_q, value_valid_d;
    logic                 error_q, error_d;
    logic                 busy_q, busy_d;
    logic [6:0]           sum;
    logic                 key_digit;
    logic                 key_clear;

    assign key_digit = key_code_i <= 4'd9;
    assign key_clear = key_code_i == CLEAR_CODE;
    assign sum       = {3'b000, tens_q} * 7'd10 + {3'b000, units_q};

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        units_d = units_q;
        timer_d = timer_q;

        case (state_q)
            StIdle: begin
                if (key_valid_i) begin
                    if (key_digit) begin
                        tens_d  = key_code_i;
                        timer_d = '0;
                        state_d = StWait2;
                    end else if (!key_clear) begin
                        state_d = StErr;
                    end
                end
            end
            StWait2: begin
                timer_d = timer_q + 1'b1;
                // A key on the timeout cycle takes priority over the timeout.
                if (key_valid_i) begin
                    if (key_digit) begin
                        units_d = key_code_i;
                        state_d = StCheck;
                    end else if (key_clear) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StErr;
                    end
                end else if (timer_q == TimerLast) begin
                    state_d = StErr;
                end
            end
            StCheck: begin
                if (tens_q <= 4'd9 && units_q <= 4'd9 && sum <= MaxVal) begin
                    state_d = StDone;
                end else begin
                    state_d = StErr;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so pulses coincide with DONE/ERR.
    always_comb begin
        value_valid_d = state_d == StDone;
        error_d       = state_d == StErr;
        busy_d        = state_d != StIdle;
        value_bcd_d   = (state_d == StDone) ? {tens_q, units_q} : value_bcd_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            tens_q        <= '0;
            units_q       <= '0;
            timer_q       <= '0;
            value_bcd_q   <= '0;
            value_valid_q <= 1'b0;
            error_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tens_q        <= tens_d;
            units_q       <= units_d;
            timer_q       <= timer_d;
            value_bcd_q   <= value_bcd_d;
            value_valid_q <= value_valid_d;
            error_q       <= error_d;
            busy_q        <= busy_d;
        end
    end

    assign value_bcd_o   = value_bcd_q;
    assign value_valid_o = value_valid_q;
    assign error_o       = error_q;
    assign busy_o        = busy_q;
    assign state_dbg_o   = state_q;

`ifdef DIGIT_ENTRY_BIN_OUT_EN
    logic [6:0] value_bin_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_bin_q <= '0;
        end else if (state_d == StDone) begin
            value_bin_q <= sum;
        end
    end

    assign value_bin_o = value_bin_q;
`endif

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed self-checking bench for digit_entry_ctrl (TIMEOUT_CYCLES=10, MAX_VALUE=50).
module tb_digit_entry_ctrl;

    logic       clk_i;
    logic       rst_ni;
    logic       key_valid_i;
    logic [3:0] key_code_i;
    logic [7:0] value_bcd_o;
    logic       value_valid_o;
    logic       error_o;
    logic       busy_o;
    logic [2:0] state_dbg_o;
`ifdef DIGIT_ENTRY_BIN_OUT_EN
    logic [6:0] value_bin_o;
`endif

    int npass;
    int ntotal;
    logic acc;

    digit_entry_ctrl #(
        .TIMEOUT_CYCLES(10),
        .TIMER_W       (8),
        .MAX_VALUE     (50),
        .CLEAR_CODE    (4'hC)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .key_valid_i  (key_valid_i),
        .key_code_i   (key_code_i),
        .value_bcd_o  (value_bcd_o),
        .value_valid_o(value_valid_o),
        .error_o      (error_o),
        .busy_o       (busy_o),
        .state_dbg_o  (state_dbg_o)
`ifdef DIGIT_ENTRY_BIN_OUT_EN
        ,
        .value_bin_o  (value_bin_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Strobe one key for a single cycle; returns at the negedge after the sampling edge.
    task automatic press(input logic [3:0] code);
        @(negedge clk_i);
        key_valid_i = 1'b1;
        key_code_i  = code;
        @(negedge clk_i);
        key_valid_i = 1'b0;
        key_code_i  = 4'h0;
    endtask

    initial begin
        npass       = 0;
        ntotal      = 0;
        rst_ni      = 1'b0;
        key_valid_i = 1'b0;
        key_code_i  = 4'h0;

        // Reset then idle
        repeat (3) @(negedge clk_i);
        chk("rst_bcd", value_bcd_o, 8'h00);
        chk("rst_busy", {7'd0, busy_o}, 8'd0);
        chk("rst_state", {5'd0, state_dbg_o}, 8'd0);
        chk("rst_pulses", {6'd0, value_valid_o, error_o}, 8'd0);
        rst_ni = 1'b1;
        acc = 1'b0;
        repeat (20) begin
            @(negedge clk_i);
            acc = acc | value_valid_o | error_o | busy_o;
        end
        chk("idle_quiet", {7'd0, acc}, 8'd0);

        // Accept 4,2
        press(4'd4);
        chk("acc_wait2", {5'd0, state_dbg_o}, 8'd1);
        chk("acc_busy", {7'd0, busy_o}, 8'd1);
        repeat (2) @(negedge clk_i);
        press(4'd2);
        chk("acc_check", {5'd0, state_dbg_o}, 8'd2);
        chk("acc_early_valid", {7'd0, value_valid_o}, 8'd0);
        @(negedge clk_i);
        chk("acc_valid", {7'd0, value_valid_o}, 8'd1);
        chk("acc_err", {7'd0, error_o}, 8'd0);
        chk("acc_bcd", value_bcd_o, 8'h42);
`ifdef DIGIT_ENTRY_BIN_OUT_EN
        chk("acc_bin", {1'b0, value_bin_o}, 8'd42);
`endif
        @(negedge clk_i);
        chk("acc_valid_once", {7'd0, value_valid_o}, 8'd0);
        chk("acc_idle", {5'd0, state_dbg_o}, 8'd0);

        // Reject non-digit second key
        press(4'd7);
        press(4'hB);
        chk("rej_err", {7'd0, error_o}, 8'd1);
        chk("rej_state", {5'd0, state_dbg_o}, 8'd4);
        chk("rej_bcd_kept", value_bcd_o, 8'h42);
        @(negedge clk_i);
        chk("rej_err_once", {7'd0, error_o}, 8'd0);
        chk("rej_idle", {5'd0, state_dbg_o}, 8'd0);

        // Clear aborts silently
        press(4'd3);
        press(4'hC);
        chk("clr_state", {5'd0, state_dbg_o}, 8'd0);
        chk("clr_pulses", {6'd0, value_valid_o, error_o}, 8'd0);
        @(negedge clk_i);
        chk("clr_pulses2", {6'd0, value_valid_o, error_o}, 8'd0);

        // Range check against MAX_VALUE=50
        press(4'd5);
        press(4'd1);
        @(negedge clk_i);
        chk("rng51_err", {7'd0, error_o}, 8'd1);
        chk("rng51_valid", {7'd0, value_valid_o}, 8'd0);
        chk("rng51_bcd", value_bcd_o, 8'h42);
        press(4'd5);
        press(4'd0);
        @(negedge clk_i);
        chk("rng50_valid", {7'd0, value_valid_o}, 8'd1);
        chk("rng50_bcd", value_bcd_o, 8'h50);

        // Timeout: error visible at the 11th negedge after WAIT2 entry
        press(4'd9);
        acc = (state_dbg_o != 3'd1) | error_o;
        repeat (9) begin
            @(negedge clk_i);
            acc = acc | (state_dbg_o != 3'd1) | error_o;
        end
        chk("to_hold", {7'd0, acc}, 8'd0);
        @(negedge clk_i);
        chk("to_err", {7'd0, error_o}, 8'd1);
        chk("to_state", {5'd0, state_dbg_o}, 8'd4);
        @(negedge clk_i);

        // Digit on the timeout cycle wins
        press(4'd1);
        repeat (8) @(negedge clk_i);
        press(4'd4);
        chk("to_win_check", {5'd0, state_dbg_o}, 8'd2);
        chk("to_win_noerr", {7'd0, error_o}, 8'd0);
        @(negedge clk_i);
        chk("to_win_valid", {7'd0, value_valid_o}, 8'd1);
        chk("to_win_bcd", value_bcd_o, 8'h14);

        // Reset mid-entry
        press(4'd6);
        chk("mid_wait2", {5'd0, state_dbg_o}, 8'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_state", {5'd0, state_dbg_o}, 8'd0);
        chk("mid_rst_bcd", value_bcd_o, 8'h00);
        @(negedge clk_i);
        rst_ni = 1'b1;
        press(4'd1);
        press(4'd2);
        @(negedge clk_i);
        chk("mid_valid", {7'd0, value_valid_o}, 8'd1);
        chk("mid_bcd", value_bcd_o, 8'h12);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
